// File: rtl/shtp_pkg.sv
// Shared types and constants for the BNO085 SHTP packet reader and its
// downstream report parser.
package shtp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSSU,
    ST_ISSUE,
    ST_WAIT,
    ST_CSHOLD,
    ST_DONE
  } shtp_rd_state_t;

  localparam int SHTP_HDR_BYTES = 4;

  localparam logic [7:0] CH_COMMAND = 8'd0;
  localparam logic [7:0] CH_EXEC    = 8'd1;
  localparam logic [7:0] CH_CONTROL = 8'd2;
  localparam logic [7:0] CH_REPORTS = 8'd3;
  localparam logic [7:0] CH_WAKE    = 8'd4;
  localparam logic [7:0] CH_GYRO_RV = 8'd5;

  localparam logic [7:0] RPT_ROTATION_VECTOR  = 8'h05;
  localparam logic [7:0] RPT_GYROSCOPE        = 8'h02;
  localparam logic [7:0] RPT_PRODUCT_ID_RESP  = 8'hF8;
  localparam logic [7:0] RPT_GET_FEATURE_RESP = 8'hFC;

  // Header length field: bit 7 of the MSB is the continuation flag, not length.
  function automatic logic [14:0] shtp_len(input logic [7:0] msb, input logic [7:0] lsb);
    return {msb[6:0], lsb};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/shtp_packet_reader.sv
// Reads one SHTP packet from the BNO085 over the shared byte SPI master each
// time H_INTN is low, streaming payload bytes to the report parser.
module shtp_packet_reader
  import shtp_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 32,
  parameter int CS_SETUP_CYC = 4,
  parameter int BYTE_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           int_n,
  output logic                           spi_start,
  output logic                           spi_tx_valid,
  output logic [7:0]                     spi_tx_data,
  input  logic                           spi_tx_ready,
  input  logic                           spi_rx_valid,
  input  logic [7:0]                     spi_rx_data,
  input  logic                           spi_busy,
  output logic                           cs_n,
  output logic [7:0]                     pkt_channel,
  output logic [7:0]                     pkt_seq,
  output logic [14:0]                    pkt_len,
  output logic                           out_valid,
  output logic [7:0]                     out_data,
  output logic [$clog2(MAX_PAYLOAD)-1:0] out_index,
  output logic                           pkt_done,
  output logic                           pkt_truncated,
  output logic                           error,
  output logic                           busy
);

  localparam int IDX_W = $clog2(MAX_PAYLOAD);
  localparam int CS_W  = $clog2(CS_SETUP_CYC + 1);
  localparam int TO_W  = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CS_W-1:0] CS_LOAD   = CS_W'(CS_SETUP_CYC);
  localparam logic [15:0]     TRUNC_LEN = 16'(SHTP_HDR_BYTES + MAX_PAYLOAD);

  shtp_rd_state_t state_q, state_d;

  logic            int_s;
  logic [CS_W-1:0] cs_cnt;
  logic [TO_W-1:0] wait_cnt;
  logic [15:0]     byte_cnt;
  logic [15:0]     byte_nxt;
  logic [15:0]     pay_idx;
  logic [7:0]      len_lo;
  logic            start_pkt;
  logic            issue_fire;
  logic            rx_fire;
  logic            byte_timeout;
  logic            last_byte;
  logic            cnt_expired;
  logic            pay_fwd;

  sync_2ff #(.RESET_VAL(1'b1)) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_n),
    .q     (int_s)
  );

  assign byte_nxt    = byte_cnt + 16'd1;
  assign pay_idx     = byte_cnt - 16'(SHTP_HDR_BYTES);
  assign cnt_expired = (cs_cnt == CS_W'(1));

  // cs_cnt doubles as the cs_n-high guard after a packet, so a held-low
  // INT cannot restart until the sensor has seen a full deselect.
  assign start_pkt    = (state_q == ST_IDLE) && enable && !int_s && (cs_cnt == '0);
  assign issue_fire   = (state_q == ST_ISSUE) && spi_tx_ready && !spi_busy;
  assign rx_fire      = (state_q == ST_WAIT) && spi_rx_valid;
  assign byte_timeout = (state_q == ST_WAIT) && !spi_rx_valid &&
                        (wait_cnt == TO_W'(BYTE_TIMEOUT - 1));

  // Header-only packets (length 0..4) end after the seq byte.
  assign last_byte = (byte_cnt >= 16'(SHTP_HDR_BYTES - 1)) &&
                     ((pkt_len <= 15'(SHTP_HDR_BYTES)) || (byte_nxt == {1'b0, pkt_len}));
  assign pay_fwd   = (byte_cnt >= 16'(SHTP_HDR_BYTES)) && (pay_idx < 16'(MAX_PAYLOAD));

  assign busy         = (state_q != ST_IDLE);
  assign spi_tx_valid = spi_start;
  assign spi_tx_data  = 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_pkt) state_d = ST_CSSU;
      ST_CSSU:   if (cnt_expired) state_d = ST_ISSUE;
      ST_ISSUE:  if (issue_fire) state_d = ST_WAIT;
      ST_WAIT: begin
        if (rx_fire)           state_d = last_byte ? ST_CSHOLD : ST_ISSUE;
        else if (byte_timeout) state_d = ST_CSHOLD;
      end
      ST_CSHOLD: if (cnt_expired) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n          <= 1'b1;
      spi_start     <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_index     <= '0;
      pkt_channel   <= '0;
      pkt_seq       <= '0;
      pkt_len       <= '0;
      pkt_done      <= 1'b0;
      pkt_truncated <= 1'b0;
      error         <= 1'b0;
      cs_cnt        <= '0;
      wait_cnt      <= '0;
      byte_cnt      <= '0;
      len_lo        <= '0;
    end else begin
      spi_start <= 1'b0;
      out_valid <= 1'b0;
      pkt_done  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_cnt != '0) cs_cnt <= cs_cnt - CS_W'(1);
          if (start_pkt) begin
            cs_n          <= 1'b0;
            cs_cnt        <= CS_LOAD;
            error         <= 1'b0;
            pkt_truncated <= 1'b0;
            byte_cnt      <= '0;
          end
        end
        ST_CSSU: cs_cnt <= cs_cnt - CS_W'(1);
        ST_ISSUE: begin
          wait_cnt <= '0;
          if (issue_fire) spi_start <= 1'b1;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + TO_W'(1);
          if (rx_fire) begin
            byte_cnt <= byte_nxt;
            case (byte_cnt)
              16'd0:   len_lo      <= spi_rx_data;
              16'd1:   pkt_len     <= shtp_len(spi_rx_data, len_lo);
              16'd2:   pkt_channel <= spi_rx_data;
              16'd3:   pkt_seq     <= spi_rx_data;
              default: begin
                if (pay_fwd) begin
                  out_valid <= 1'b1;
                  out_data  <= spi_rx_data;
                  out_index <= pay_idx[IDX_W-1:0];
                end
              end
            endcase
            if (last_byte) cs_cnt <= CS_LOAD;
          end else if (byte_timeout) begin
            error  <= 1'b1;
            cs_cnt <= CS_LOAD;
          end
        end
        ST_CSHOLD: begin
          cs_cnt <= cs_cnt - CS_W'(1);
          if (cnt_expired) cs_n <= 1'b1;
        end
        ST_DONE: begin
          pkt_done      <= !error;
          pkt_truncated <= ({1'b0, pkt_len} > TRUNC_LEN);
          cs_cnt        <= CS_LOAD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shtp_packet_reader.sv
// Bench for shtp_packet_reader: randomized mock SPI master fed from a byte
// queue, outputs compared with a packet-level reference model.
module tb_shtp_packet_reader;
  import shtp_pkg::*;

  localparam int MAXP = 32;
  localparam int CSS  = 4;
  localparam int BTO  = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            int_n = 1'b1;
  logic            spi_start, spi_tx_valid;
  logic [7:0]      spi_tx_data;
  logic            spi_tx_ready = 1'b0;
  logic            spi_rx_valid = 1'b0;
  logic [7:0]      spi_rx_data = 8'h00;
  logic            spi_busy = 1'b0;
  logic            cs_n;
  logic [7:0]      pkt_channel, pkt_seq;
  logic [14:0]     pkt_len;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [$clog2(MAXP)-1:0] out_index;
  logic            pkt_done, pkt_truncated, error, busy;

  always #5 clk = ~clk;

  shtp_packet_reader #(
    .MAX_PAYLOAD  (MAXP),
    .CS_SETUP_CYC (CSS),
    .BYTE_TIMEOUT (BTO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .int_n         (int_n),
    .spi_start     (spi_start),
    .spi_tx_valid  (spi_tx_valid),
    .spi_tx_data   (spi_tx_data),
    .spi_tx_ready  (spi_tx_ready),
    .spi_rx_valid  (spi_rx_valid),
    .spi_rx_data   (spi_rx_data),
    .spi_busy      (spi_busy),
    .cs_n          (cs_n),
    .pkt_channel   (pkt_channel),
    .pkt_seq       (pkt_seq),
    .pkt_len       (pkt_len),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_index     (out_index),
    .pkt_done      (pkt_done),
    .pkt_truncated (pkt_truncated),
    .error         (error),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Byte stream the mock slave returns, plus what the monitor observed.
  logic [7:0] mq[$];
  logic [7:0] obs_data[$];
  int         obs_idx[$];
  logic [7:0] exp_data[$];
  int         exp_idx[$];
  int         exp_len, exp_ch, exp_seq;
  bit         exp_trunc;

  int midx = 0, start_cnt = 0, done_cnt = 0, cs_falls = 0;
  int hi_run = 0, min_gap = 1000000, lat = 0;
  int drop_at = 1 << 30;
  bit pending = 1'b0, mock_clr = 1'b0, cs_prev = 1'b1;

  // Mock SPI master and output monitor; everything happens on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      spi_rx_valid = 1'b0;
      if (mock_clr) begin
        midx = 0; start_cnt = 0; done_cnt = 0; cs_falls = 0;
        hi_run = 0; min_gap = 1000000; pending = 1'b0; spi_busy = 1'b0;
        obs_data.delete(); obs_idx.delete();
      end else begin
        if (out_valid) begin
          obs_data.push_back(out_data);
          obs_idx.push_back(int'(out_index));
        end
        if (pkt_done) done_cnt++;
        if (cs_n) hi_run++;
        else begin
          if (cs_prev) begin
            if (cs_falls > 0 && hi_run < min_gap) min_gap = hi_run;
            cs_falls++;
          end
          hi_run = 0;
        end
        if (pending) begin
          if (lat == 0) begin
            spi_rx_valid = 1'b1;
            spi_rx_data  = (midx < mq.size()) ? mq[midx] : 8'h00;
            midx++;
            pending  = 1'b0;
            spi_busy = 1'b0;
          end else lat--;
        end else if (spi_start) begin
          start_cnt++;
          if (midx < drop_at) begin
            pending  = 1'b1;
            lat      = $urandom_range(0, 4);
            spi_busy = 1'b1;
          end else midx++;
        end
      end
      cs_prev = cs_n;
      spi_tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic clear_mock();
    mock_clr = 1'b1;
    @(negedge clk);
    #1 mock_clr = 1'b0;
  endtask

  task automatic add_pkt(input int len, input int ch, input int seq);
    logic [14:0] l;
    l = len[14:0];
    mq.push_back(l[7:0]);
    mq.push_back({1'($urandom_range(0, 1)), l[14:8]});
    mq.push_back(ch[7:0]);
    mq.push_back(seq[7:0]);
    for (int i = 4; i < len; i++) mq.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: what a packet starting at mq[base] must produce.
  task automatic model_pkt(input int base, output int total);
    logic [7:0] b0, b1;
    int len;
    b0 = mq[base];
    b1 = mq[base+1];
    len = int'({b1[6:0], b0});
    total = (len <= 4) ? 4 : len;
    for (int i = 4; i < total; i++)
      if (i - 4 < MAXP) begin
        exp_data.push_back(mq[base+i]);
        exp_idx.push_back(i - 4);
      end
    exp_len   = len;
    exp_ch    = int'(mq[base+2]);
    exp_seq   = int'(mq[base+3]);
    exp_trunc = (len > 4) && (len - 4 > MAXP);
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_nout"}, obs_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      check({tag, "_data"}, obs_data[i], exp_data[i]);
      check({tag, "_idx"}, obs_idx[i], exp_idx[i]);
    end
  endtask

  task automatic wait_busy(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (busy) begin ok = 1'b1; break; end
    end
    check({tag, "_start"}, ok, 1);
  endtask

  task automatic run_pkt(input string tag);
    int total;
    bit ok;
    exp_data.delete(); exp_idx.delete();
    model_pkt(0, total);
    clear_mock();
    int_n = 1'b0;
    wait_busy(tag);
    check({tag, "_errclr"}, error, 0);
    int_n = 1'b1;
    enable = 1'($urandom_range(0, 1));
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    enable = 1'b1;
    check({tag, "_done"}, ok, 1);
    check({tag, "_csn"}, cs_n, 1);
    check({tag, "_len"}, pkt_len, exp_len);
    check({tag, "_ch"}, pkt_channel, exp_ch);
    check({tag, "_seq"}, pkt_seq, exp_seq);
    check({tag, "_trunc"}, pkt_truncated, exp_trunc);
    check({tag, "_err"}, error, 0);
    check({tag, "_nstart"}, start_cnt, total);
    compare_obs(tag);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_ndone"}, done_cnt, 1);
    check({tag, "_idle"}, busy, 0);
  endtask

  logic [7:0] rv [19] = '{8'h13, 8'h00, 8'h03, 8'h00, 8'h05, 8'h01, 8'h03, 8'h00, 8'hE8,
                          8'h03, 8'hD0, 8'h07, 8'hB8, 8'h0B, 8'hA0, 8'h0F, 8'h00, 8'h00, 8'h00};

  initial begin
    int t1, t2, cyc;
    bit ok;

    repeat (3) @(negedge clk);
    #1;
    check("rst_csn", cs_n, 1);
    check("rst_start", spi_start, 0);
    check("rst_txv", spi_tx_valid, 0);
    check("rst_txd", spi_tx_data, 0);
    check("rst_outv", out_valid, 0);
    check("rst_outd", out_data, 0);
    check("rst_outi", out_index, 0);
    check("rst_len", pkt_len, 0);
    check("rst_ch", pkt_channel, 0);
    check("rst_seq", pkt_seq, 0);
    check("rst_done", pkt_done, 0);
    check("rst_trunc", pkt_truncated, 0);
    check("rst_err", error, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    mq.delete();
    foreach (rv[i]) mq.push_back(rv[i]);
    run_pkt("rv");
    check("rv_byte4", (obs_data.size() > 4) ? obs_data[4] : 8'h00, 8'hE8);

    mq.delete();
    add_pkt(0, CH_COMMAND, 0);
    mq[1] = 8'h00;
    run_pkt("zero");

    mq.delete();
    add_pkt(40, CH_REPORTS, 7);
    run_pkt("over");

    for (int k = 0; k < 6; k++) begin
      mq.delete();
      add_pkt($urandom_range(0, 60), $urandom_range(0, 5), $urandom_range(0, 255));
      run_pkt("rand");
    end

    // Slave stops answering after the first header byte.
    mq.delete();
    add_pkt(10, CH_CONTROL, 1);
    drop_at = 1;
    clear_mock();
    int_n = 1'b0;
    wait_busy("to");
    int_n = 1'b1;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < BTO + 300; i++) begin
      @(negedge clk); #1;
      cyc++;
      if (error) begin ok = 1'b1; break; end
    end
    check("to_err", ok, 1);
    check("to_late", cyc >= BTO, 1);
    repeat (CSS + 4) @(negedge clk);
    #1;
    check("to_csn", cs_n, 1);
    check("to_errhold", error, 1);
    check("to_nodone", done_cnt, 0);
    check("to_idle", busy, 0);
    drop_at = 1 << 30;
    mq.delete();
    add_pkt(9, CH_REPORTS, 2);
    run_pkt("after_to");

    // Reset while payload byte 7 is on the bus.
    mq.delete();
    add_pkt(20, CH_REPORTS, 9);
    clear_mock();
    int_n = 1'b0;
    wait_busy("mrst");
    int_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (midx >= 8) begin ok = 1'b1; break; end
    end
    check("mrst_reach", ok, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_csn", cs_n, 1);
    check("mrst_start", spi_start, 0);
    check("mrst_outv", out_valid, 0);
    check("mrst_len", pkt_len, 0);
    check("mrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check("mrst_csn2", cs_n, 1);
    check("mrst_outd", out_data, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("mrst_nodone", done_cnt, 0);
    check("mrst_idle", busy, 0);

    // INT held low across two packets.
    mq.delete();
    add_pkt(8, CH_REPORTS, 1);
    exp_data.delete(); exp_idx.delete();
    model_pkt(0, t1);
    add_pkt(12, CH_GYRO_RV, 2);
    model_pkt(t1, t2);
    clear_mock();
    int_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (cs_falls >= 2) begin ok = 1'b1; break; end
    end
    check("b2b_second", ok, 1);
    int_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= 2) begin ok = 1'b1; break; end
    end
    check("b2b_done", ok, 1);
    check("b2b_nstart", start_cnt, t1 + t2);
    check("b2b_gap", min_gap >= CSS + 2, 1);
    check("b2b_len", pkt_len, exp_len);
    check("b2b_ch", pkt_channel, exp_ch);
    compare_obs("b2b");
    repeat (20) @(negedge clk);
    #1;
    check("b2b_ndone", done_cnt, 2);
    check("b2b_idle", busy, 0);

    // enable low blocks a start.
    enable = 1'b0;
    clear_mock();
    int_n = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("dis_nstart", start_cnt, 0);
    check("dis_idle", busy, 0);
    check("dis_csn", cs_n, 1);
    int_n = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shtp_packet_reader.md
Name: shtp_packet_reader

Overview:
Sequences the shared byte-level SPI master to read one complete SHTP packet from the BNO085 whenever the sensor asserts INT. Handles chip select, the 4-byte SHTP header, length decode and payload bytes. Payload bytes stream out to the report parser (rotation vector / gyroscope decoder), which sits downstream in the BNO085 controller.

Parameters:
MAX_PAYLOAD, 32, payload bytes forwarded per packet; bytes beyond this are clocked but dropped.
CS_SETUP_CYC, 4, clk cycles between cs_n fall and first byte start, and between last byte and cs_n rise.
BYTE_TIMEOUT, 1024, max clk cycles from byte start to spi_rx_valid before the reader aborts.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  when high, a low int_n starts a packet read
int_n  in  1  BNO085 H_INTN, asynchronous, active low
spi_start  out  1  one-cycle byte start request to SPI master
spi_tx_valid  out  1  asserted with spi_start
spi_tx_data  out  8  always 8'h00 (read-only dummy byte)
spi_tx_ready  in  1  master can accept a byte
spi_rx_valid  in  1  one-cycle pulse, received byte valid
spi_rx_data  in  8  received byte
spi_busy  in  1  master shifting
cs_n  out  1  BNO085 chip select, active low
pkt_channel  out  8  header byte 2 of the current packet
pkt_seq  out  8  header byte 3 of the current packet
pkt_len  out  15  header length, continuation bit masked
out_valid  out  1  one-cycle pulse per forwarded payload byte
out_data  out  8  payload byte
out_index  out  $clog2(MAX_PAYLOAD)  payload byte offset, 0-based
pkt_done  out  1  one-cycle pulse after cs_n returns high on a good packet
pkt_truncated  out  1  level; set at pkt_done when payload length > MAX_PAYLOAD, cleared at next packet start
error  out  1  level; set on byte timeout, cleared at next packet start
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): cs_n=1, spi_start=0, spi_tx_valid=0, spi_tx_data=0, out_valid=0, out_data=0, out_index=0, pkt_channel=0, pkt_seq=0, pkt_len=0, pkt_done=0, pkt_truncated=0, error=0, busy=0; FSM goes to IDLE. Reset mid-packet raises cs_n immediately; no partial pkt_done.
- int_n passes through a 2-flop synchronizer (int_s). Detection is level-based.
- FSM: IDLE -> CSSU -> ISSUE -> WAIT -> (ISSUE | CSHOLD) -> DONE -> IDLE.
- IDLE: leave when enable && !int_s. Clear error/pkt_truncated. Drive cs_n=0. Load the setup counter.
- CSSU: count CS_SETUP_CYC cycles, then go to ISSUE.
- ISSUE: wait for spi_tx_ready && !spi_busy. Then assert spi_start=spi_tx_valid=1 for exactly one cycle and go to WAIT. Byte counter (16 bit) tracks the position in the packet.
- WAIT: on spi_rx_valid, capture the byte by position:
  - bytes 0,1: length LSB/MSB; pkt_len={b1[6:0],b0}.
  - byte 2: channel. byte 3: seq.
  - bytes >=4: payload. If payload index < MAX_PAYLOAD, pulse out_valid with out_data=byte and out_index=index, in the cycle after spi_rx_valid.
- End condition is evaluated after each byte:
  - After byte 3: if pkt_len<=4 (includes 0 = no data), go to CSHOLD.
  - Otherwise go to CSHOLD when the byte count equals pkt_len, else back to ISSUE.
- Timeout: the WAIT counter reaching BYTE_TIMEOUT sets error and goes to CSHOLD; pkt_done is not pulsed.
- CSHOLD: count CS_SETUP_CYC, then cs_n=1, go to DONE.
- DONE: pulse pkt_done for one cycle if no error. Set pkt_truncated if pkt_len-4 > MAX_PAYLOAD. Return to IDLE.
  - int_n still low in IDLE starts the next packet immediately.
  - int_n edges during a packet are ignored.
- enable dropping mid-packet does not abort the packet; it only blocks the next start.
- pkt_channel, pkt_seq and pkt_len hold their values until overwritten by the next header.

Decomposition:
- shtp_pkg holds:
  - state enum shtp_rd_state_t;
  - SHTP_HDR_BYTES=4;
  - channel constants: CH_COMMAND=0, CH_EXEC=1, CH_CONTROL=2, CH_REPORTS=3, CH_WAKE=4, CH_GYRO_RV=5;
  - report ID constants: RPT_ROTATION_VECTOR=8'h05, RPT_GYROSCOPE=8'h02, RPT_PRODUCT_ID_RESP=8'hF8, RPT_GET_FEATURE_RESP=8'hFC.
- One natural sub-module: sync_2ff (int_n synchronizer). Counters and FSM stay inline.

Test Plan:
- Rotation vector packet: header 13 00 03 00, payload 05 01 03 00 E8 03 D0 07 B8 0B A0 0F 00 00 00 -> pkt_len=19, pkt_channel=3, 15 out_valid pulses with index 0..14, out_data[4]=E8, then pkt_done=1, pkt_truncated=0, cs_n high.
- Zero-length header 00 00 00 00 -> exactly 4 spi_start pulses, no out_valid, pkt_done=1.
- Oversize packet: pkt_len=40 with MAX_PAYLOAD=32 -> 40 spi_start pulses, 32 out_valid pulses (index 0..31), pkt_truncated=1 at pkt_done.
- Byte timeout: mock master never returns spi_rx_valid after byte 1 -> error=1 after BYTE_TIMEOUT cycles, cs_n=1, no pkt_done; the next int_n low clears error and reads normally.
- Reset mid-payload (byte 7): cs_n=1 and all outputs at reset values during reset; no pkt_done.
- int_n held low with enable=1 across two packets -> two back-to-back reads, cs_n high for at least CS_SETUP_CYC+2 cycles between them; enable=0 -> no spi_start.
